// File: rtl/clock_alarm_core.sv
`default_nettype none
// ============================================================================
// Module   : clock_alarm_core
// Brief    : BCD HH:MM:SS timekeeper with 1 Hz prescaler, validated load port,
//            multi-channel alarms with ring/snooze/auto-stop FSM, 12/24 h view.
// Revision : 1.0 - initial release
// ============================================================================
module clock_alarm_core #(
    parameter int CLK_FREQ   = 12000000,
    parameter int ALARM_NUM  = 2,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 set_valid,
    input  logic [3:0]           set_sel,
    input  logic [7:0]           set_hour,
    input  logic [7:0]           set_minute,
    input  logic [7:0]           set_second,
    input  logic [ALARM_NUM-1:0] alarm_en,
    input  logic                 snooze,
    input  logic                 dismiss,
    input  logic                 hour12_mode,
    output logic [7:0]           Hour,
    output logic [7:0]           Minute,
    output logic [7:0]           Second,
    output logic [7:0]           disp_hour,
    output logic                 pm,
    output logic                 tick_1hz,
    output logic                 set_ack,
    output logic                 set_err,
    output logic                 ring,
    output logic [2:0]           ring_id
);

    localparam int          PW         = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
    localparam int          SNZ_TICKS  = SNOOZE_MIN * 60;
    localparam int          SW         = $clog2(SNZ_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2
    } state_t;

    logic [PW-1:0]        r_presc;
    logic [7:0]           r_hour, r_min, r_sec;
    logic                 r_tick, r_ack, r_err;
    state_t               r_state;
    logic [7:0]           r_ring_cnt;
    logic [SW-1:0]        r_snz_cnt;
    logic [2:0]           r_ring_id;
    logic                 r_ring;

    logic                 w_hour_ok, w_min_ok, w_sec_ok, w_sel_time, w_sel_ok, w_set_ok;
    logic                 w_load_time, w_load_alarm, w_tick_due;
    logic [8:0]           w_sec_inc, w_min_inc;
    logic [7:0]           w_hour_inc;
    logic [ALARM_NUM-1:0] w_match;
    logic                 w_hit;
    logic [2:0]           w_hit_id;
    logic [7:0]           w_en8;
    logic                 w_id_en;
    logic [7:0]           w_disp;
    logic                 w_pm;

    // Returns {carry, next} for a BCD 00..59 field.
    function automatic logic [8:0] inc60(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) return {1'b1, 8'h00};
            else                return {1'b0, v[7:4] + 4'd1, 4'h0};
        end
        return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        if (v == 8'h23)        return 8'h00;
        if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'h0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign w_hour_ok    = (set_hour[3:0] <= 4'd9) && (set_hour <= 8'h23);
    assign w_min_ok     = (set_minute[3:0] <= 4'd9) && (set_minute <= 8'h59);
    assign w_sec_ok     = (set_second[3:0] <= 4'd9) && (set_second <= 8'h59);
    assign w_sel_time   = (set_sel == 4'd0);
    assign w_sel_ok     = (set_sel <= 4'(ALARM_NUM));
    // Seconds only matter for a time load, so an alarm load ignores that field.
    assign w_set_ok     = w_hour_ok && w_min_ok && w_sel_ok && (!w_sel_time || w_sec_ok);
    assign w_load_time  = set_valid && w_set_ok && w_sel_time;
    assign w_load_alarm = set_valid && w_set_ok && !w_sel_time;
    assign w_tick_due   = (r_presc == PRESC_MAX);

    assign w_sec_inc  = inc60(r_sec);
    assign w_min_inc  = inc60(r_min);
    assign w_hour_inc = inc_hour(r_hour);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_presc <= '0;
            r_hour  <= 8'h00;
            r_min   <= 8'h00;
            r_sec   <= 8'h00;
            r_tick  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_ack  <= set_valid && w_set_ok;
            r_err  <= set_valid && !w_set_ok;
            if (w_load_time) begin
                r_hour  <= set_hour;
                r_min   <= set_minute;
                r_sec   <= set_second;
                r_presc <= '0;
            end else if (w_tick_due) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
                r_sec   <= w_sec_inc[7:0];
                if (w_sec_inc[8]) begin
                    r_min <= w_min_inc[7:0];
                    if (w_min_inc[8]) r_hour <= w_hour_inc;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < ALARM_NUM; gi++) begin : g_alarm
            logic [7:0] r_al_hour, r_al_min;
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_al_hour <= 8'h00;
                    r_al_min  <= 8'h00;
                end else if (w_load_alarm && (set_sel == 4'(gi + 1))) begin
                    r_al_hour <= set_hour;
                    r_al_min  <= set_minute;
                end
            end
            assign w_match[gi] = alarm_en[gi] && (r_al_hour == r_hour) && (r_al_min == r_min);
        end
    endgenerate

    // Descending scan so the lowest matching channel is the last one written.
    always_comb begin
        w_hit_id = 3'd0;
        for (int i = ALARM_NUM - 1; i >= 0; i--) begin
            if (w_match[i]) w_hit_id = 3'(i);
        end
    end

    assign w_hit   = r_tick && (r_sec == 8'h00) && (|w_match);
    assign w_en8   = 8'(alarm_en);
    assign w_id_en = w_en8[r_ring_id];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_ring     <= 1'b0;
            r_ring_id  <= 3'd0;
            r_ring_cnt <= 8'd0;
            r_snz_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_state    <= S_RING;
                        r_ring     <= 1'b1;
                        r_ring_id  <= w_hit_id;
                        r_ring_cnt <= 8'd0;
                    end
                end
                S_RING: begin
                    if (!w_id_en || dismiss) begin
                        r_state <= S_IDLE;
                        r_ring  <= 1'b0;
                    end else if (snooze) begin
                        r_state   <= S_SNOOZE;
                        r_ring    <= 1'b0;
                        r_snz_cnt <= SW'(SNZ_TICKS);
                    end else if (r_tick) begin
                        if (r_ring_cnt == 8'(RING_SEC - 1)) begin
                            r_state <= S_IDLE;
                            r_ring  <= 1'b0;
                        end else begin
                            r_ring_cnt <= r_ring_cnt + 8'd1;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (!w_id_en || dismiss) begin
                        r_state <= S_IDLE;
                        r_ring  <= 1'b0;
                    end else if (r_tick) begin
                        if (r_snz_cnt == SW'(1)) begin
                            r_state    <= S_RING;
                            r_ring     <= 1'b1;
                            r_ring_cnt <= 8'd0;
                        end else begin
                            r_snz_cnt <= r_snz_cnt - SW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ring  <= 1'b0;
                end
            endcase
        end
    end

    // 20..23 cannot be shifted down by 0x12 without a BCD borrow, hence the split.
    always_comb begin
        w_disp = r_hour;
        w_pm   = 1'b0;
        if (hour12_mode) begin
            if (r_hour == 8'h00) begin
                w_disp = 8'h12;
            end else if (r_hour == 8'h12) begin
                w_pm = 1'b1;
            end else if (r_hour > 8'h12) begin
                w_pm = 1'b1;
                if (r_hour[7:4] == 4'd1)      w_disp = r_hour - 8'h12;
                else if (r_hour[3:0] < 4'd2)  w_disp = {4'h0, r_hour[3:0] + 4'd8};
                else                          w_disp = {4'h1, r_hour[3:0] - 4'd2};
            end
        end
    end

    assign Hour      = r_hour;
    assign Minute    = r_min;
    assign Second    = r_sec;
    assign disp_hour = w_disp;
    assign pm        = w_pm;
    assign tick_1hz  = r_tick;
    assign set_ack   = r_ack;
    assign set_err   = r_err;
    assign ring      = r_ring;
    assign ring_id   = r_ring_id;

endmodule
`default_nettype wire

// File: tb/tb_clock_alarm_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_alarm_core
// Brief    : Scoreboard bench for clock_alarm_core (CLK_FREQ=4, 2 channels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_alarm_core;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       set_valid;
    logic [3:0] set_sel;
    logic [7:0] set_hour, set_minute, set_second;
    logic [1:0] alarm_en;
    logic       snooze, dismiss, hour12_mode;
    logic [7:0] Hour, Minute, Second, disp_hour;
    logic       pm, tick_1hz, set_ack, set_err, ring;
    logic [2:0] ring_id;

    typedef struct {
        logic       r;
        logic [2:0] id;
    } ring_t;

    logic [23:0] q_tick[$];
    logic        q_set[$];
    ring_t       q_ring[$];
    logic        chk_tick = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    clock_alarm_core #(
        .CLK_FREQ  (4),
        .ALARM_NUM (2),
        .RING_SEC  (3),
        .SNOOZE_MIN(1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .set_valid  (set_valid),
        .set_sel    (set_sel),
        .set_hour   (set_hour),
        .set_minute (set_minute),
        .set_second (set_second),
        .alarm_en   (alarm_en),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .hour12_mode(hour12_mode),
        .Hour       (Hour),
        .Minute     (Minute),
        .Second     (Second),
        .disp_hour  (disp_hour),
        .pm         (pm),
        .tick_1hz   (tick_1hz),
        .set_ack    (set_ack),
        .set_err    (set_err),
        .ring       (ring),
        .ring_id    (ring_id)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT output with no expected entry", name);
    endtask

    // Monitor: samples 1 ns after each falling edge, pops on every DUT event.
    initial begin
        logic  prev_ring;
        ring_t er;
        prev_ring = 1'b0;
        forever begin
            @(negedge sys_clk);
            #1;
            if (tick_1hz && chk_tick) begin
                if (q_tick.size() == 0) unexpected("tick_time");
                else check("tick_time", {8'h0, Hour, Minute, Second}, {8'h0, q_tick.pop_front()});
            end
            if (set_ack || set_err) begin
                if (q_set.size() == 0) unexpected("set_resp");
                else check("set_resp{ack,err}", {30'h0, set_ack, set_err},
                           q_set.pop_front() ? 32'h2 : 32'h1);
            end
            if (ring !== prev_ring) begin
                if (q_ring.size() == 0) unexpected("ring_edge");
                else begin
                    er = q_ring.pop_front();
                    check("ring_edge", {31'h0, ring}, {31'h0, er.r});
                    if (er.r) check("ring_edge_id", {29'h0, ring_id}, {29'h0, er.id});
                end
            end
            prev_ring = ring;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
        #2;
    endtask

    task automatic load(input logic [3:0] sel, input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s, input logic ok);
        set_valid  = 1'b1;
        set_sel    = sel;
        set_hour   = h;
        set_minute = m;
        set_second = s;
        q_set.push_back(ok);
        cyc(1);
        set_valid = 1'b0;
    endtask

    task automatic push_ring(input logic r, input logic [2:0] id);
        ring_t e;
        e.r  = r;
        e.id = id;
        q_ring.push_back(e);
    endtask

    initial begin
        sys_rst_n   = 1'b0;
        set_valid   = 1'b0;
        set_sel     = 4'd0;
        set_hour    = 8'h00;
        set_minute  = 8'h00;
        set_second  = 8'h00;
        alarm_en    = 2'b00;
        snooze      = 1'b0;
        dismiss     = 1'b0;
        hour12_mode = 1'b0;

        // Reset state and free-running seconds
        cyc(3);
        check("rst_time", {8'h0, Hour, Minute, Second}, 32'h000000);
        check("rst_disp_pm", {23'h0, disp_hour, pm}, 32'h0);
        check("rst_ring", {28'h0, ring, ring_id}, 32'h0);
        check("rst_pulses", {29'h0, tick_1hz, set_ack, set_err}, 32'h0);
        sys_rst_n = 1'b1;
        chk_tick  = 1'b1;
        q_tick.push_back(24'h000001);
        q_tick.push_back(24'h000002);
        q_tick.push_back(24'h000003);
        cyc(12);
        check("t1_second", {24'h0, Second}, 32'h03);
        chk_tick = 1'b0;

        // Day rollover and 12 h view
        chk_tick = 1'b1;
        q_tick.push_back(24'h235959);
        q_tick.push_back(24'h000000);
        load(4'd0, 8'h23, 8'h59, 8'h58, 1'b1);
        cyc(8);
        check("t2_rollover", {8'h0, Hour, Minute, Second}, 32'h000000);
        chk_tick = 1'b0;
        hour12_mode = 1'b1;
        #1;
        check("t2_12am", {23'h0, disp_hour, pm}, {23'h0, 8'h12, 1'b0});
        load(4'd0, 8'h12, 8'h59, 8'h59, 1'b1);
        check("t2_12pm", {23'h0, disp_hour, pm}, {23'h0, 8'h12, 1'b1});
        cyc(4);
        check("t2_13h", {15'h0, Hour, disp_hour, pm}, {15'h0, 8'h13, 8'h01, 1'b1});
        load(4'd0, 8'h20, 8'h15, 8'h00, 1'b1);
        check("t2_20h", {23'h0, disp_hour, pm}, {23'h0, 8'h08, 1'b1});
        load(4'd0, 8'h23, 8'h15, 8'h00, 1'b1);
        check("t2_23h", {23'h0, disp_hour, pm}, {23'h0, 8'h11, 1'b1});
        load(4'd0, 8'h09, 8'h15, 8'h00, 1'b1);
        check("t2_09am", {23'h0, disp_hour, pm}, {23'h0, 8'h09, 1'b0});
        hour12_mode = 1'b0;
        load(4'd0, 8'h23, 8'h15, 8'h00, 1'b1);
        check("t2_24h", {23'h0, disp_hour, pm}, {23'h0, 8'h23, 1'b0});

        // Rejected loads leave time and alarms untouched
        load(4'd0, 8'h10, 8'h20, 8'h30, 1'b1);
        load(4'd0, 8'h24, 8'h00, 8'h00, 1'b0);
        load(4'd1, 8'h07, 8'h1A, 8'h00, 1'b0);
        load(4'd7, 8'h07, 8'h30, 8'h00, 1'b0);
        check("t3_time_kept", {8'h0, Hour, Minute, Second}, 32'h102030);
        alarm_en = 2'b01;
        push_ring(1'b1, 3'd0);
        load(4'd0, 8'h23, 8'h59, 8'h59, 1'b1);
        cyc(5);
        check("t3_alarm0_still_0000", {28'h0, ring, ring_id}, {28'h0, 1'b1, 3'd0});
        push_ring(1'b0, 3'd0);
        dismiss = 1'b1;
        cyc(1);
        dismiss = 1'b0;
        check("t3_dismiss", {31'h0, ring}, 32'h0);

        // Two matching channels, lowest wins, auto-stop after 3 ticks
        load(4'd1, 8'h07, 8'h30, 8'h00, 1'b1);
        load(4'd2, 8'h07, 8'h30, 8'h00, 1'b1);
        alarm_en = 2'b11;
        push_ring(1'b1, 3'd0);
        push_ring(1'b0, 3'd0);
        load(4'd0, 8'h07, 8'h29, 8'h59, 1'b1);
        cyc(5);
        check("t4_ring_on", {28'h0, ring, ring_id}, {28'h0, 1'b1, 3'd0});
        cyc(11);
        check("t4_ring_before_stop", {31'h0, ring}, 32'h1);
        cyc(1);
        check("t4_autostop", {31'h0, ring}, 32'h0);

        // Snooze for 60 ticks, then snooze+dismiss together
        alarm_en = 2'b10;
        push_ring(1'b1, 3'd1);
        push_ring(1'b0, 3'd1);
        load(4'd0, 8'h07, 8'h29, 8'h59, 1'b1);
        cyc(5);
        check("t5_ring_ch1", {28'h0, ring, ring_id}, {28'h0, 1'b1, 3'd1});
        snooze = 1'b1;
        cyc(1);
        snooze = 1'b0;
        check("t5_snoozed", {31'h0, ring}, 32'h0);
        push_ring(1'b1, 3'd1);
        cyc(238);
        check("t5_before_reringing", {31'h0, ring}, 32'h0);
        cyc(1);
        check("t5_rering", {28'h0, ring, ring_id}, {28'h0, 1'b1, 3'd1});
        push_ring(1'b0, 3'd1);
        snooze  = 1'b1;
        dismiss = 1'b1;
        cyc(1);
        snooze  = 1'b0;
        dismiss = 1'b0;
        check("t5_dismiss_wins", {31'h0, ring}, 32'h0);

        // Load on the edge a tick is due
        load(4'd0, 8'h01, 8'h02, 8'h03, 1'b1);
        cyc(3);
        chk_tick = 1'b1;
        q_tick.push_back(24'h050608);
        load(4'd0, 8'h05, 8'h06, 8'h07, 1'b1);
        check("t6_no_tick_on_load", {31'h0, tick_1hz}, 32'h0);
        check("t6_loaded_time", {8'h0, Hour, Minute, Second}, 32'h050607);
        cyc(4);
        check("t6_next_tick", {23'h0, tick_1hz, Second}, {23'h0, 1'b1, 8'h08});
        chk_tick = 1'b0;

        // alarm_en drop during RING
        alarm_en = 2'b01;
        push_ring(1'b1, 3'd0);
        push_ring(1'b0, 3'd0);
        load(4'd0, 8'h07, 8'h29, 8'h59, 1'b1);
        cyc(5);
        check("t6_ring_on", {31'h0, ring}, 32'h1);
        alarm_en = 2'b00;
        cyc(1);
        check("t6_en_drop", {31'h0, ring}, 32'h0);

        // Asynchronous reset mid-RING
        alarm_en = 2'b10;
        push_ring(1'b1, 3'd1);
        push_ring(1'b0, 3'd1);
        load(4'd0, 8'h07, 8'h29, 8'h59, 1'b1);
        cyc(5);
        check("t6_ring_ch1", {28'h0, ring, ring_id}, {28'h0, 1'b1, 3'd1});
        sys_rst_n = 1'b0;
        #1;
        check("t6_async_time", {8'h0, Hour, Minute, Second}, 32'h000000);
        check("t6_async_ring", {28'h0, ring, ring_id}, 32'h0);
        check("t6_async_misc", {20'h0, disp_hour, pm, tick_1hz, set_ack, set_err}, 32'h0);
        cyc(2);
        sys_rst_n = 1'b1;
        cyc(3);

        check("tick_queue_left", 32'(q_tick.size()), 32'h0);
        check("set_queue_left", 32'(q_set.size()), 32'h0);
        check("ring_queue_left", 32'(q_ring.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
